// File: rtl/t07_game_pkg.sv
// -----------------------------------------------------------------------------
// t07_game_pkg
// Shared types and constants for the parametrised bomb-game controller.
//   game_state_t : MENU / PLAY / LOST / WON / PAUSE encoding seen on game_state
//   difficulty_t : EASY / NORM / HARD encoding seen on difficulty
//   SELECT..BACK : one-hot button codes, bit order {BACK,LEFT,DOWN,RIGHT,UP,SELECT}
//   is_press     : strobe qualified, strictly one-hot button press
// -----------------------------------------------------------------------------
package t07_game_pkg;

   typedef enum logic [2:0] {
      ST_MENU  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_LOST  = 3'd2,
      ST_WON   = 3'd3,
      ST_PAUSE = 3'd4
   } game_state_t;

   typedef enum logic [1:0] {
      DIFF_EASY = 2'd0,
      DIFF_NORM = 2'd1,
      DIFF_HARD = 2'd2
   } difficulty_t;

   localparam logic [5:0] SELECT = 6'b000001;
   localparam logic [5:0] UP     = 6'b000010;
   localparam logic [5:0] RIGHT  = 6'b000100;
   localparam logic [5:0] DOWN   = 6'b001000;
   localparam logic [5:0] LEFT   = 6'b010000;
   localparam logic [5:0] BACK   = 6'b100000;

   // A press needs the strobe and exactly one button bit; multi-bit values
   // come from bouncing or chorded keys and are dropped.
   function automatic logic is_press(input logic strobe, input logic [5:0] button);
      return strobe && (button != 6'd0) && ((button & (button - 6'd1)) == 6'd0);
   endfunction

endpackage

// File: rtl/t07_game_countdown.sv
// -----------------------------------------------------------------------------
// t07_game_countdown
// Seconds-remaining register for the game controller.
//   clk, rst    : clock, asynchronous active-high reset (loads RST_VAL)
//   load        : load load_val this cycle (highest priority)
//   load_val    : start time to load
//   tick        : subtract one second (saturating)
//   penalty     : subtract PENALTY_SEC seconds (saturating), combines with tick
//   freeze      : hold time_left when not loading
//   time_left   : current seconds remaining
//   zero_next   : the tick/penalty applied this cycle would leave zero
// -----------------------------------------------------------------------------
module t07_game_countdown #(
   parameter int TIMER_W     = 9,
   parameter int PENALTY_SEC = 10,
   parameter int RST_VAL     = 180
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   input  logic               tick,
   input  logic               penalty,
   input  logic               freeze,
   output logic [TIMER_W-1:0] time_left,
   output logic               zero_next
);

   // Penalty clipped to 2^TIMER_W so it always fits the extended subtractor.
   localparam logic [TIMER_W:0] PEN =
      (PENALTY_SEC >= (1 << TIMER_W)) ? (TIMER_W+1)'(1 << TIMER_W)
                                      : (TIMER_W+1)'(PENALTY_SEC);

   logic [TIMER_W-1:0] after_tick;
   logic [TIMER_W-1:0] time_next;
   logic [TIMER_W:0]   pen_diff;

   function automatic logic [TIMER_W-1:0] sat_dec1(input logic [TIMER_W-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   always_comb begin
      after_tick = tick ? sat_dec1(time_left) : time_left;
      // The extra MSB acts as the borrow: set means the penalty overshot zero.
      pen_diff   = {1'b0, after_tick} - PEN;
      time_next  = after_tick;
      if (penalty) begin
         time_next = pen_diff[TIMER_W] ? '0 : pen_diff[TIMER_W-1:0];
      end
   end

   assign zero_next = (time_next == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         time_left <= TIMER_W'(RST_VAL);
      end else if (load) begin
         time_left <= load_val;
      end else if (!freeze) begin
         time_left <= time_next;
      end
   end

endmodule

// File: rtl/t07_game_ctrl_param.sv
// -----------------------------------------------------------------------------
// t07_game_ctrl_param
// Game-control FSM for the bomb game with difficulty selection, pause,
// configurable lives/modules and an internal countdown with strike penalty.
//   clk, rst       : 12 MHz clock, asynchronous active-high reset
//   strobe, button : button sample strobe and one-hot button code
//   tick_1hz       : one pulse per second
//   error          : strike pulse from a module
//   mod_clear      : module-solved pulse
//   game_state     : MENU=0 PLAY=1 LOST=2 WON=3 PAUSE=4
//   difficulty     : EASY=0 NORM=1 HARD=2
//   lives          : lives remaining
//   mods_left      : modules still to clear
//   time_left      : seconds remaining
//   timer_clear    : one-cycle pulse after MENU->PLAY
//   activate_rand  : one-cycle pulse after MENU->PLAY
// -----------------------------------------------------------------------------
module t07_game_ctrl_param
   import t07_game_pkg::*;
#(
   parameter int MAX_LIVES   = 3,
   parameter int NUM_MODULES = 4,
   parameter int TIMER_W     = 9,
   parameter int T_EASY      = 300,
   parameter int T_NORM      = 180,
   parameter int T_HARD      = 120,
   parameter int PENALTY_SEC = 10
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             strobe,
   input  logic [5:0]                       button,
   input  logic                             tick_1hz,
   input  logic                             error,
   input  logic                             mod_clear,
   output logic [2:0]                       game_state,
   output logic [1:0]                       difficulty,
   output logic [$clog2(MAX_LIVES+1)-1:0]   lives,
   output logic [$clog2(NUM_MODULES+1)-1:0] mods_left,
   output logic [TIMER_W-1:0]               time_left,
   output logic                             timer_clear,
   output logic                             activate_rand
);

   localparam int LW = $clog2(MAX_LIVES+1);
   localparam int MW = $clog2(NUM_MODULES+1);
   localparam logic [LW-1:0] LIVES_INIT = LW'(MAX_LIVES);
   localparam logic [MW-1:0] MODS_INIT  = MW'(NUM_MODULES);

   game_state_t        state;
   difficulty_t        diff;
   difficulty_t        diff_menu;
   logic               press;
   logic               btn_sel, btn_up, btn_down, btn_back;
   logic [LW-1:0]      lives_nxt;
   logic [MW-1:0]      mods_nxt;
   logic               cd_load;
   logic [TIMER_W-1:0] cd_load_val;
   logic               cd_freeze;
   logic               cd_penalty;
   logic               zero_next;

   function automatic logic [TIMER_W-1:0] start_time(input difficulty_t d);
      case (d)
         DIFF_EASY: start_time = TIMER_W'(T_EASY);
         DIFF_HARD: start_time = TIMER_W'(T_HARD);
         default:   start_time = TIMER_W'(T_NORM);
      endcase
   endfunction

   function automatic logic [LW-1:0] sat_dec_lives(input logic [LW-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   function automatic logic [MW-1:0] sat_dec_mods(input logic [MW-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   assign press    = is_press(strobe, button);
   assign btn_sel  = press && (button == SELECT);
   assign btn_up   = press && (button == UP);
   assign btn_down = press && (button == DOWN);
   assign btn_back = press && (button == BACK);

   // Difficulty as it will be after this edge while in MENU.
   always_comb begin
      diff_menu = diff;
      if (btn_up && (diff != DIFF_HARD)) begin
         diff_menu = difficulty_t'(diff + 2'd1);
      end else if (btn_down && (diff != DIFF_EASY)) begin
         diff_menu = difficulty_t'(diff - 2'd1);
      end
   end

   assign lives_nxt = error     ? sat_dec_lives(lives)    : lives;
   assign mods_nxt  = mod_clear ? sat_dec_mods(mods_left) : mods_left;

   // MENU reloads every cycle so time_left tracks the difficulty being
   // chosen on the same edge; PAUSE->MENU and LOST/WON->MENU reload once.
   always_comb begin
      cd_load     = 1'b0;
      cd_load_val = start_time(diff);
      unique case (state)
         ST_MENU: begin
            cd_load     = 1'b1;
            cd_load_val = start_time(diff_menu);
         end
         ST_PAUSE:        cd_load = btn_back;
         ST_LOST, ST_WON: cd_load = press;
         default:         cd_load = 1'b0;
      endcase
   end

   assign cd_freeze  = (state != ST_PLAY);
   assign cd_penalty = error && (diff == DIFF_HARD);

   t07_game_countdown #(
      .TIMER_W     (TIMER_W),
      .PENALTY_SEC (PENALTY_SEC),
      .RST_VAL     (T_NORM)
   ) u_countdown (
      .clk       (clk),
      .rst       (rst),
      .load      (cd_load),
      .load_val  (cd_load_val),
      .tick      (tick_1hz),
      .penalty   (cd_penalty),
      .freeze    (cd_freeze),
      .time_left (time_left),
      .zero_next (zero_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_MENU;
         diff          <= DIFF_NORM;
         lives         <= LIVES_INIT;
         mods_left     <= MODS_INIT;
         timer_clear   <= 1'b0;
         activate_rand <= 1'b0;
      end else begin
         timer_clear   <= 1'b0;
         activate_rand <= 1'b0;
         unique case (state)
            ST_MENU: begin
               diff <= diff_menu;
               if (btn_sel) begin
                  state         <= ST_PLAY;
                  lives         <= LIVES_INIT;
                  mods_left     <= MODS_INIT;
                  timer_clear   <= 1'b1;
                  activate_rand <= 1'b1;
               end
            end
            ST_PLAY: begin
               // All simultaneous events land together; losing beats winning.
               lives     <= lives_nxt;
               mods_left <= mods_nxt;
               if ((lives_nxt == '0) || zero_next) begin
                  state <= ST_LOST;
               end else if (mods_nxt == '0) begin
                  state <= ST_WON;
               end else if (btn_back) begin
                  state <= ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (btn_sel) begin
                  state <= ST_PLAY;
               end else if (btn_back) begin
                  state     <= ST_MENU;
                  lives     <= LIVES_INIT;
                  mods_left <= MODS_INIT;
               end
            end
            ST_LOST, ST_WON: begin
               if (press) begin
                  state     <= ST_MENU;
                  lives     <= LIVES_INIT;
                  mods_left <= MODS_INIT;
               end
            end
            default: state <= ST_MENU;
         endcase
      end
   end

   assign game_state = state;
   assign difficulty = diff;

endmodule

// File: tb/tb_t07_game_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_t07_game_ctrl_param
// Self-checking bench: a rule-level model of the game is stepped on every
// clock edge and compared with the DUT on every falling edge; directed
// scenarios pin the model with hand-computed values, then random play runs.
// -----------------------------------------------------------------------------
module tb_t07_game_ctrl_param;

   localparam int MAX_LIVES   = 3;
   localparam int NUM_MODULES = 4;
   localparam int TIMER_W     = 9;
   localparam int T_EASY      = 300;
   localparam int T_NORM      = 180;
   localparam int T_HARD      = 120;
   localparam int PENALTY_SEC = 10;

   localparam logic [5:0] B_SEL   = 6'b000001;
   localparam logic [5:0] B_UP    = 6'b000010;
   localparam logic [5:0] B_RIGHT = 6'b000100;
   localparam logic [5:0] B_DOWN  = 6'b001000;
   localparam logic [5:0] B_LEFT  = 6'b010000;
   localparam logic [5:0] B_BACK  = 6'b100000;

   logic       tb_clk = 1'b0;
   logic       rst;
   logic       strobe;
   logic [5:0] button;
   logic       tick_1hz;
   logic       error;
   logic       mod_clear;
   logic [2:0] game_state;
   logic [1:0] difficulty;
   logic [1:0] lives;
   logic [2:0] mods_left;
   logic [8:0] time_left;
   logic       timer_clear;
   logic       activate_rand;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // Model state: plain integers following the game rules.
   int m_state, m_diff, m_lives, m_mods, m_time, m_pulse;

   always #5 tb_clk = ~tb_clk;

   t07_game_ctrl_param #(
      .MAX_LIVES   (MAX_LIVES),
      .NUM_MODULES (NUM_MODULES),
      .TIMER_W     (TIMER_W),
      .T_EASY      (T_EASY),
      .T_NORM      (T_NORM),
      .T_HARD      (T_HARD),
      .PENALTY_SEC (PENALTY_SEC)
   ) dut (
      .clk           (tb_clk),
      .rst           (rst),
      .strobe        (strobe),
      .button        (button),
      .tick_1hz      (tick_1hz),
      .error         (error),
      .mod_clear     (mod_clear),
      .game_state    (game_state),
      .difficulty    (difficulty),
      .lives         (lives),
      .mods_left     (mods_left),
      .time_left     (time_left),
      .timer_clear   (timer_clear),
      .activate_rand (activate_rand)
   );

   function automatic int start_of(input int d);
      return (d == 0) ? T_EASY : ((d == 1) ? T_NORM : T_HARD);
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_diff = 1; m_lives = MAX_LIVES; m_mods = NUM_MODULES;
      m_time = T_NORM; m_pulse = 0;
   endtask

   task automatic model_reload();
      m_lives = MAX_LIVES; m_mods = NUM_MODULES; m_time = start_of(m_diff);
   endtask

   // One clock edge worth of game rules, using the inputs held across it.
   task automatic model_step();
      bit pr;
      int nl, nm, nt;
      if (rst) begin
         model_reset();
         return;
      end
      pr = strobe && ($countones(button) == 1);
      m_pulse = 0;
      case (m_state)
         0: begin
            if (pr && button == B_UP   && m_diff < 2) m_diff++;
            if (pr && button == B_DOWN && m_diff > 0) m_diff--;
            m_time = start_of(m_diff);
            if (pr && button == B_SEL) begin
               m_state = 1; model_reload(); m_pulse = 1;
            end
         end
         1: begin
            nl = m_lives - (error ? 1 : 0);
            if (nl < 0) nl = 0;
            nm = m_mods - (mod_clear ? 1 : 0);
            if (nm < 0) nm = 0;
            nt = m_time - (tick_1hz ? 1 : 0) - ((error && m_diff == 2) ? PENALTY_SEC : 0);
            if (nt < 0) nt = 0;
            m_lives = nl; m_mods = nm; m_time = nt;
            if (nl == 0 || nt == 0)          m_state = 2;
            else if (nm == 0)                m_state = 3;
            else if (pr && button == B_BACK) m_state = 4;
         end
         4: begin
            if (pr && button == B_SEL) m_state = 1;
            else if (pr && button == B_BACK) begin
               m_state = 0; model_reload();
            end
         end
         default: begin
            if (pr) begin
               m_state = 0; model_reload();
            end
         end
      endcase
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge tb_clk) begin
      if (chk_en && !rst) begin
         chk("game_state",    int'(game_state),    m_state);
         chk("difficulty",    int'(difficulty),    m_diff);
         chk("lives",         int'(lives),         m_lives);
         chk("mods_left",     int'(mods_left),     m_mods);
         chk("time_left",     int'(time_left),     m_time);
         chk("timer_clear",   int'(timer_clear),   m_pulse);
         chk("activate_rand", int'(activate_rand), m_pulse);
      end
   end

   task automatic cyc(input bit s, input logic [5:0] b, input bit t,
                      input bit e, input bit c, input bit r);
      @(negedge tb_clk);
      #1;
      strobe = s; button = b; tick_1hz = t; error = e; mod_clear = c; rst = r;
      @(posedge tb_clk);
      model_step();
      #1;
      strobe = 1'b0; button = 6'd0; tick_1hz = 1'b0; error = 1'b0;
      mod_clear = 1'b0; rst = 1'b0;
   endtask

   task automatic press(input logic [5:0] b);
      cyc(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ev(input bit t, input bit e, input bit c);
      cyc(1'b0, 6'd0, t, e, c, 1'b0);
   endtask

   initial begin
      logic [5:0] b;
      int k;
      rst = 1'b1; strobe = 1'b0; button = 6'd0; tick_1hz = 1'b0;
      error = 1'b0; mod_clear = 1'b0;
      model_reset();
      repeat (3) @(posedge tb_clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // Reset values
      chk("rst_state", int'(game_state), 0);
      chk("rst_diff",  int'(difficulty), 1);
      chk("rst_lives", int'(lives),      3);
      chk("rst_mods",  int'(mods_left),  4);
      chk("rst_time",  int'(time_left),  180);
      chk("rst_tc",    int'(timer_clear), 0);

      // Easy win
      press(B_DOWN);
      chk("easy_diff", int'(difficulty), 0);
      chk("easy_time", int'(time_left), 300);
      press(B_SEL);
      chk("easy_play",  int'(game_state), 1);
      chk("easy_tc",    int'(timer_clear), 1);
      chk("easy_ar",    int'(activate_rand), 1);
      ev(1'b0, 1'b0, 1'b0);
      chk("easy_tc_low", int'(timer_clear), 0);
      repeat (3) ev(1'b0, 1'b0, 1'b1);
      chk("easy_mods1", int'(mods_left), 1);
      chk("easy_still_play", int'(game_state), 1);
      ev(1'b0, 1'b0, 1'b1);
      chk("easy_won", int'(game_state), 3);
      chk("easy_mods0", int'(mods_left), 0);
      press(B_LEFT);
      chk("won_to_menu", int'(game_state), 0);
      chk("won_reload_mods", int'(mods_left), 4);
      chk("won_reload_time", int'(time_left), 300);

      // Strike loss in HARD
      press(B_UP);
      press(B_UP);
      chk("hard_diff", int'(difficulty), 2);
      chk("hard_time", int'(time_left), 120);
      press(B_SEL);
      ev(1'b0, 1'b1, 1'b0);
      ev(1'b0, 1'b1, 1'b0);
      chk("strike_lives", int'(lives), 1);
      chk("strike_time",  int'(time_left), 100);
      ev(1'b0, 1'b1, 1'b0);
      chk("strike_lost",  int'(game_state), 2);
      chk("strike_lives0", int'(lives), 0);
      chk("strike_time90", int'(time_left), 90);
      press(B_RIGHT);
      chk("lost_to_menu", int'(game_state), 0);
      chk("lost_reload_lives", int'(lives), 3);

      // Timeout with simultaneous final clear: LOST wins
      press(B_SEL);
      repeat (3) ev(1'b0, 1'b0, 1'b1);
      repeat (119) ev(1'b1, 1'b0, 1'b0);
      chk("to_time1", int'(time_left), 1);
      chk("to_play",  int'(game_state), 1);
      ev(1'b1, 1'b0, 1'b1);
      chk("to_lost",  int'(game_state), 2);
      chk("to_time0", int'(time_left), 0);
      chk("to_mods0", int'(mods_left), 0);
      press(B_SEL);
      chk("to_menu", int'(game_state), 0);

      // Pause
      press(B_SEL);
      ev(1'b1, 1'b0, 1'b0);
      chk("pz_time119", int'(time_left), 119);
      press(B_BACK);
      chk("pz_pause", int'(game_state), 4);
      repeat (10) ev(1'b1, 1'b0, 1'b0);
      ev(1'b0, 1'b1, 1'b0);
      ev(1'b0, 1'b0, 1'b1);
      chk("pz_frozen_time",  int'(time_left), 119);
      chk("pz_frozen_lives", int'(lives), 3);
      chk("pz_frozen_mods",  int'(mods_left), 4);
      press(B_SEL);
      chk("pz_resume", int'(game_state), 1);
      ev(1'b1, 1'b0, 1'b0);
      chk("pz_tick", int'(time_left), 118);
      press(B_BACK);
      press(B_BACK);
      chk("pz_menu", int'(game_state), 0);
      chk("pz_reload_time", int'(time_left), 120);

      // Non-one-hot and unstrobed buttons are ignored
      press(6'b000011);
      chk("nonhot_state", int'(game_state), 0);
      cyc(1'b0, B_SEL, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("nostrobe_state", int'(game_state), 0);

      // Asynchronous reset mid-game
      press(B_SEL);
      ev(1'b0, 1'b1, 1'b0);
      ev(1'b0, 1'b1, 1'b0);
      chk("mid_lives1", int'(lives), 1);
      #1 rst = 1'b1;
      #1;
      chk("async_state", int'(game_state), 0);
      chk("async_lives", int'(lives), 3);
      chk("async_diff",  int'(difficulty), 1);
      chk("async_time",  int'(time_left), 180);
      model_reset();
      @(posedge tb_clk);
      #1 rst = 1'b0;
      press(B_UP);
      press(B_UP);
      chk("up_sat", int'(difficulty), 2);

      // Random play
      for (int i = 0; i < 4000; i++) begin
         k = int'($urandom_range(0, 9));
         case (k)
            0:       b = 6'd0;
            7:       b = 6'b000011;
            8:       b = 6'b100001;
            9:       b = 6'($urandom);
            default: b = 6'b000001 << (k - 1);
         endcase
         cyc($urandom_range(0, 5) == 0, b,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 15) == 0,
             $urandom_range(0, 11) == 0,
             $urandom_range(0, 599) == 0);
      end
      ev(1'b0, 1'b0, 1'b0);
      ev(1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
